ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder.sv | 107 ++++++++++
 tb/tb_ram_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// rtl/ram_responder.sv - single-port RAM responder with self-clear after reset
module ram_responder #(
    parameter int g_RAM_WIDTH = 11,
    parameter int g_RAM_ADDR  = 9
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_ram_en,
    input  logic                   i_ram_we,
    input  logic                   i_ram_re,
    input  logic [g_RAM_ADDR-1:0]  i_ram_addr,
    input  logic [g_RAM_WIDTH-1:0] i_ram_data,
    output logic [g_RAM_WIDTH-1:0] o_ram_data,
    output logic                   o_ram_valid,
    output logic                   o_ready,
    output logic                   o_drop
);

    localparam int DEPTH = 2 ** g_RAM_ADDR;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [g_RAM_ADDR-1:0]  cnt_q;
    logic [g_RAM_WIDTH-1:0] rdata_q;
    logic                   valid_q;
    logic                   ready_q;
    logic                   drop_q;

    logic [g_RAM_WIDTH-1:0] mem [DEPTH];

    logic                   mem_we;
    logic [g_RAM_ADDR-1:0]  mem_waddr;
    logic [g_RAM_WIDTH-1:0] mem_wdata;

    // Select the single memory write port source: the clear sweep or a CPU write.
    // Reset edges never write, so contents survive until the sweep reaches them.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        if (!i_rst) begin
            if (state_q == ST_CLEAR) begin
                mem_we = 1'b1;
            end else if (i_ram_en && i_ram_we) begin
                mem_we    = 1'b1;
                mem_waddr = i_ram_addr;
                mem_wdata = i_ram_data;
            end
        end
    end

    // Memory array write; no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: clear sweep after reset, then serve accesses with registered outputs.
    // The read samples mem before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    valid_q <= 1'b0;
                    cnt_q   <= cnt_q + g_RAM_ADDR'(1);
                    if (i_ram_en) begin
                        drop_q <= 1'b1;
                    end
                    if (&cnt_q) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                ST_READY: begin
                    valid_q <= i_ram_en && i_ram_re;
                    if (i_ram_en && i_ram_re) begin
                        rdata_q <= mem[i_ram_addr];
                    end
                end
                default: begin
                    state_q <= ST_CLEAR;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ram_data  = rdata_q;
    assign o_ram_valid = valid_q;
    assign o_ready     = ready_q;
    assign o_drop      = drop_q;

endmodule

// File: tb/tb_ram_responder.sv
// tb/tb_ram_responder.sv - scoreboard bench for ram_responder
module tb_ram_responder;

    localparam int W     = 11;
    localparam int A     = 9;
    localparam int DEPTH = 2 ** A;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_ram_en = 1'b0;
    logic         i_ram_we = 1'b0;
    logic         i_ram_re = 1'b0;
    logic [A-1:0] i_ram_addr = '0;
    logic [W-1:0] i_ram_data = '0;
    logic [W-1:0] o_ram_data;
    logic         o_ram_valid;
    logic         o_ready;
    logic         o_drop;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] model [DEPTH];
    logic [W-1:0] sb_q [$];
    logic [W-1:0] last_data = '0;
    logic         expect_ready = 1'b0;
    logic         rd_issue = 1'b0;
    logic         issued_q = 1'b0;
    logic         mon_en = 1'b0;
    logic         exp_drop = 1'b0;

    ram_responder #(
        .g_RAM_WIDTH(W),
        .g_RAM_ADDR (A)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ram_en   (i_ram_en),
        .i_ram_we   (i_ram_we),
        .i_ram_re   (i_ram_re),
        .i_ram_addr (i_ram_addr),
        .i_ram_data (i_ram_data),
        .o_ram_data (o_ram_data),
        .o_ram_valid(o_ram_valid),
        .o_ready    (o_ready),
        .o_drop     (o_drop)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge i_clk) issued_q <= rd_issue;

    // Output monitor: valid must follow an accepted read by exactly one edge.
    always @(negedge i_clk) begin
        if (mon_en) begin
            chk("valid", {31'd0, o_ram_valid}, {31'd0, issued_q});
            if (o_ram_valid) begin
                if (sb_q.size() > 0) begin
                    last_data = sb_q.pop_front();
                    chk("rdata", {21'd0, o_ram_data}, {21'd0, last_data});
                end else begin
                    chk("sb_empty", sb_q.size(), 1);
                end
            end else begin
                chk("hold", {21'd0, o_ram_data}, {21'd0, last_data});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic access(input logic en, input logic we, input logic re,
                          input logic [A-1:0] addr, input logic [W-1:0] data);
        i_ram_en   = en;
        i_ram_we   = we;
        i_ram_re   = re;
        i_ram_addr = addr;
        i_ram_data = data;
        rd_issue   = en && re && expect_ready;
        if (rd_issue) sb_q.push_back(model[addr]);
        if (en && we && expect_ready) model[addr] = data;
        tick();
        i_ram_en = 1'b0;
        i_ram_we = 1'b0;
        i_ram_re = 1'b0;
        rd_issue = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        i_rst        = 1'b1;
        expect_ready = 1'b0;
        rd_issue     = 1'b0;
        tick();
        sb_q.delete();
        last_data = '0;
        exp_drop  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Release reset and run the clear sweep; optionally poke an access or stop early.
    task automatic run_clear(input int inject_at, input int stop_at);
        i_rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == stop_at) return;
            if (i == inject_at) begin
                i_ram_en   = 1'b1;
                i_ram_we   = 1'b1;
                i_ram_re   = 1'b1;
                i_ram_addr = 9'h005;
                i_ram_data = 11'h7FF;
            end
            tick();
            i_ram_en = 1'b0;
            i_ram_we = 1'b0;
            i_ram_re = 1'b0;
            if (i == inject_at) begin
                exp_drop = 1'b1;
                chk("drop_set", {31'd0, o_drop}, 32'd1);
            end
            chk("ready_clr", {31'd0, o_ready}, (i == DEPTH - 1) ? 32'd1 : 32'd0);
        end
        expect_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        tick();
        tick();
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_valid", {31'd0, o_ram_valid}, 32'd0);
        chk("rst_data", {21'd0, o_ram_data}, 32'd0);
        chk("rst_drop", {31'd0, o_drop}, 32'd0);
        mon_en = 1'b1;

        // Plain clear, then read the top address.
        run_clear(-1, -1);
        access(1, 0, 1, 9'h1FF, 0);
        idle(2);

        // Write then read back next cycle.
        access(1, 1, 0, 9'h010, 11'h5A3);
        access(1, 0, 1, 9'h010, 0);
        idle(2);

        // Simultaneous write+read is read-first.
        access(1, 1, 0, 9'h020, 11'h111);
        access(1, 1, 1, 9'h020, 11'h222);
        access(1, 0, 1, 9'h020, 0);
        idle(2);

        // Back-to-back reads.
        access(1, 1, 0, 9'h001, 11'h101);
        access(1, 1, 0, 9'h002, 11'h202);
        access(1, 1, 0, 9'h003, 11'h303);
        access(1, 0, 1, 9'h001, 0);
        access(1, 0, 1, 9'h002, 0);
        access(1, 0, 1, 9'h003, 0);
        idle(2);

        // en=0 ignores strobes; en with no strobe is a no-op.
        access(0, 1, 1, 9'h001, 11'h7FF);
        access(1, 0, 0, 9'h001, 11'h7FE);
        access(1, 0, 1, 9'h001, 0);
        idle(1);
        chk("drop_ready", {31'd0, o_drop}, 32'd0);

        // Random traffic over a small address window.
        for (int i = 0; i < 60; i++) begin
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   9'($urandom_range(0, 15)), 11'($urandom));
        end
        idle(2);
        chk("drop_rand", {31'd0, o_drop}, 32'd0);

        // Access during clear sets sticky drop and is otherwise ignored.
        do_reset();
        run_clear(10, -1);
        chk("drop_sticky", {31'd0, o_drop}, {31'd0, exp_drop});
        access(1, 0, 1, 9'h005, 0);
        idle(2);
        chk("drop_hold", {31'd0, o_drop}, 32'd1);

        // Reset mid-clear restarts a full clear and clears drop.
        access(1, 1, 0, 9'h003, 11'h0AA);
        do_reset();
        run_clear(-1, 100);
        do_reset();
        chk("midrst_drop", {31'd0, o_drop}, 32'd0);
        chk("midrst_ready", {31'd0, o_ready}, 32'd0);
        run_clear(-1, -1);
        access(1, 0, 1, 9'h003, 0);
        idle(2);
        chk("final_drop", {31'd0, o_drop}, 32'd0);
        chk("sb_drained", sb_q.size(), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
